// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus of the pipelined carry-lookahead adder.
// The master offers operations and consumes results; the slave is the adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic [TAG_W-1:0] tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, sub, cin, tag, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
    );

    modport slave (
        input  in_valid, a, b, sub, cin, tag, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, out_tag
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// The prefix network is split over STAGES register stages; outputs come from flops.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    cla_pipe_adder_if.slave bus
);

    localparam int LVLS = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    typedef struct packed {
        gp_t              gp;    // partial prefix G/P
        logic [WIDTH-1:0] p;     // raw per-bit propagate, needed for the sum
        logic             c0;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Number of prefix levels completed by the time an op sits in register k.
    function automatic int cut(input int k);
        return (k * LVLS) / STAGES;
    endfunction

    function automatic gp_t run_levels(input gp_t x, input int first, input int last);
        gp_t cur;
        gp_t nxt;
        cur = x;
        for (int l = 0; l < LVLS; l++) begin
            nxt = cur;
            if (l >= first && l < last) begin
                for (int j = 0; j < WIDTH - (1 << l); j++) begin
                    nxt.g[j + (1 << l)] = cur.g[j + (1 << l)] | (cur.p[j + (1 << l)] & cur.g[j]);
                    nxt.p[j + (1 << l)] = cur.p[j + (1 << l)] & cur.p[j];
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic stage_t step(input stage_t s, input int k);
        stage_t r;
        r    = s;
        r.gp = run_levels(s.gp, cut(k - 1), cut(k));
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] final_g(input stage_t s);
        return run_levels(s.gp, cut(STAGES - 1), LVLS).g;
    endfunction

    stage_t             prep;
    stage_t             src [STAGES];
    logic [WIDTH-1:0]   b_eff;
    logic               c0_in;
    logic [STAGES:1]    vld;
    logic [STAGES:1]    en;
    logic [STAGES-1:0]  v_in;
    logic               in_ready_int;

    // c0 enters as bit -1 with P = 0; folding it into bit 0's generate keeps
    // the network at log2(WIDTH) levels.
    always_comb begin
        b_eff          = bus.sub ? ~bus.b : bus.b;
        c0_in          = bus.sub | bus.cin;
        prep.p         = bus.a ^ b_eff;
        prep.gp.g      = bus.a & b_eff;
        prep.gp.g[0]   = (bus.a[0] & b_eff[0]) | (prep.p[0] & c0_in);
        prep.gp.p      = prep.p;
        prep.gp.p[0]   = 1'b0;
        prep.c0        = c0_in;
        prep.tag       = bus.tag;
    end

    assign src[0] = prep;

    // A register may load when it is empty or its contents move on this edge.
    // NOTE: every always_comb output gets a value on every path (here a default
    // first) so no latch is inferred.
    always_comb begin
        en         = '0;
        en[STAGES] = !vld[STAGES] || bus.out_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            en[k] = !vld[k] || en[k + 1];
        end
    end

    assign in_ready_int = en[1] && !flush && !rst;
    assign bus.in_ready = in_ready_int;

    always_comb begin
        v_in    = '0;
        v_in[0] = bus.in_valid && in_ready_int;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = vld[k];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (en[k]) vld[k] <= v_in[k - 1];
            end
        end
    end

    // NOTE: intermediate data flops are not reset; the valid bits alone decide
    // whether their contents mean anything.
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        stage_t q;
        always_ff @(posedge clk) begin
            if (en[k] && v_in[k - 1]) q <= step(src[k - 1], k);
        end
        assign src[k] = q;
    end

    // c[i] is the carry into bit i; c[WIDTH] is the carry out.
    stage_t           last;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] next_sum;

    assign last     = src[STAGES - 1];
    assign c        = {final_g(last), last.c0};
    assign next_sum = last.p ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.zero    <= 1'b0;
            bus.out_tag <= '0;
        end else if (en[STAGES] && v_in[STAGES - 1]) begin
            bus.sum     <= next_sum;
            bus.cout    <= c[WIDTH];
            bus.ovf     <= c[WIDTH] ^ c[WIDTH - 1];
            bus.zero    <= (next_sum == '0);
            bus.out_tag <= last.tag;
        end
    end

    assign bus.out_valid = vld[STAGES];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed corner cases, backpressure, flush, reset and a
// randomized stream scored against an arithmetic reference model.
module tb_cla_pipe_adder;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    cla_pipe_adder #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t mq[$];

    // Plain integer arithmetic: A + (sub ? ~B : B) + (sub ? 1 : cin).
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin, input logic [TW-1:0] tag);
        exp_t       e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be};
        if (sub || cin) full = full + 1'b1;
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
        e.zero = (e.sum == '0);
        e.tag  = tag;
        return e;
    endfunction

    // Scoreboard: any visible result must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst === 1'b1 || flush === 1'b1) begin
            mq.delete();
        end else begin
            if (bus.out_valid === 1'b1) begin
                check("model_nonempty", 64'(mq.size() != 0), 64'd1);
                if (mq.size() != 0) begin
                    check("sum",     64'(bus.sum),     64'(mq[0].sum));
                    check("cout",    64'(bus.cout),    64'(mq[0].cout));
                    check("ovf",     64'(bus.ovf),     64'(mq[0].ovf));
                    check("zero",    64'(bus.zero),    64'(mq[0].zero));
                    check("out_tag", 64'(bus.out_tag), 64'(mq[0].tag));
                    if (bus.out_ready) void'(mq.pop_front());
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
                mq.push_back(model(bus.a, bus.b, bus.sub, bus.cin, bus.tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, input logic [W-1:0] e_sum, input logic e_cout,
                         input logic e_ovf, input logic e_zero);
        int lat;
        lat = 0;
        bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
        bus.tag = TW'($urandom); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("op_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (lat == 0) begin
                @(negedge clk);
                if (bus.out_valid) lat = n;
            end
        end
        check("op_latency", 64'(lat), 64'(S));
        check("op_sum",  64'(bus.sum),  64'(e_sum));
        check("op_cout", 64'(bus.cout), 64'(e_cout));
        check("op_ovf",  64'(bus.ovf),  64'(e_ovf));
        check("op_zero", 64'(bus.zero), 64'(e_zero));
        tick();
    endtask

    task automatic offer(input logic [TW-1:0] t, output bit ok);
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.sub = 1'($urandom); bus.cin = 1'($urandom);
        bus.tag = t; bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!ok) begin
                @(negedge clk);
                ok = bus.in_ready;
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_tag(input string name, input logic [TW-1:0] e_tag);
        bit            seen;
        logic [TW-1:0] t;
        seen = 1'b0;
        t    = '0;
        for (int n = 0; n < 8; n++) begin
            if (!seen) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    t    = bus.out_tag;
                end
                tick();
            end
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
        check({name, "_tag"},  64'(t),    64'(e_tag));
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       begin v = '0; v[W-1] = 1'b1; end
            3:       begin v = '1; v[W-1] = 1'b0; end
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit            ok;
        int            nvalid;
        logic [TW-1:0] got[$];

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        bus.cin = 1'b0; bus.tag = '0; bus.out_ready = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum",       64'(bus.sum),       64'd0);
        check("rst_cout",      64'(bus.cout),      64'd0);
        check("rst_ovf",       64'(bus.ovf),       64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Directed corner cases
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op(32'd3,         32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op(32'd5,         32'd5, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op(32'd10,        32'd3, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        do_op(32'd1,         32'd1, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        // Backpressure: fill the pipe, hold, then release
        bus.out_ready = 1'b0;
        offer(5'd1, ok); check("bp_accept1", 64'(ok), 64'd1);
        offer(5'd2, ok); check("bp_accept2", 64'(ok), 64'd1);
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'b0; bus.cin = 1'b0;
        bus.tag = 5'd3; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
            check("bp_out_valid",    64'(bus.out_valid), 64'd1);
            check("bp_out_tag_held", 64'(bus.out_tag),   64'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("bp_in_ready_rise", 64'(bus.in_ready), 64'd1);
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_tag);
            tick();
            if (i == 0) bus.in_valid = 1'b0;
        end
        check("bp_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) check("bp_order", 64'(got[k]), 64'(k + 1));
        end

        // Flush with two ops in flight and a third offered in the flush cycle
        bus.out_ready = 1'b0;
        offer(5'd4, ok); check("fl_accept4", 64'(ok), 64'd1);
        offer(5'd5, ok); check("fl_accept5", 64'(ok), 64'd1);
        bus.tag = 5'd6; bus.in_valid = 1'b1; bus.out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        offer(5'd7, ok); check("fl_accept7", 64'(ok), 64'd1);
        wait_tag("fl_next", 5'd7);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        offer(5'd8, ok); check("rs_accept8", 64'(ok), 64'd1);
        offer(5'd9, ok); check("rs_accept9", 64'(ok), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rs_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rs_out_valid", 64'(bus.out_valid), 64'd0);
        check("rs_sum",       64'(bus.sum),       64'd0);
        check("rs_out_tag",   64'(bus.out_tag),   64'd0);
        check("rs_in_ready",  64'(bus.in_ready),  64'd1);
        tick();
        bus.out_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
            tick();
        end
        check("rs_no_stale", 64'(nvalid), 64'd0);

        // Randomized stream with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.a         = rand_operand();
            bus.b         = rand_operand();
            bus.sub       = 1'($urandom);
            bus.cin       = 1'($urandom);
            bus.tag       = TW'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        check("drain_empty", 64'(mq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the pipelined ALU. It builds a parallel-prefix (Kogge-Stone) carry network from group generate/propagate combines over WIDTH bits and cuts it into STAGES register stages. A valid/ready handshake carries operations through the stages, with backpressure and flush. It sits behind the ALU operand muxes and serves multi-cycle or high-frequency configurations where the single-cycle CLA limits timing.

## Interface
- WIDTH, 32: operand width; power of two, 4..64.
- STAGES, 2: register stages (latency); 1..log2(WIDTH).
- TAG_W, 5: width of the sideband tag (e.g. destination register) carried alongside each operation.

- clk  input  1  clock; one clock domain, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  operation offered.
- in_ready  output  1  block accepts the operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B + cin.
- cin  input  1  carry-in, used only when sub = 0.
- tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Operand prep:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Per bit: g_i = a_i & b_eff_i, p_i = a_i ^ b_eff_i.
- Prefix network: log2(WIDTH) levels. Each combine is G = Gh | (Ph & Gl) and P = Ph & Pl. c0 is folded in as bit −1 (G = c0, P = 0).
- Carries: carry into bit i = G[i−1:−1]. sum_i = p_i ^ c_i. cout = c_WIDTH. ovf = c_WIDTH ^ c_(WIDTH−1).
- Stage cuts: stage k (1..STAGES−1) registers the network state after level floor(k·L/STAGES), where L = log2(WIDTH). The final stage registers sum/cout/ovf/zero/out_tag. Outputs always come straight from flops.
- Each stage holds a valid bit plus the data it needs: partial G/P, p, sub, tag.
- Handshake:
  - Transfer happens when valid && ready are both high on a rising edge.
  - Stage STAGES advances when out_ready || !out_valid.
  - Stage k advances when stage k+1 is empty or advancing.
  - in_ready = !valid[1] || advance[1], forced 0 while flush or rst is high.
  - Ready is a combinational chain back from out_ready; no skid buffer.
- A stalled stage holds all its data and valid bit unchanged. out_* stay stable while out_valid && !out_ready.
- Flush: all valid bits clear on the next edge. Any input offered in the flush cycle is dropped and not accepted. Data registers may keep stale values.
- Reset: all valid bits = 0. sum, cout, ovf, zero, out_tag = 0; out_valid = 0; in_ready = 0 during the reset cycle. rst overrides flush and handshake.

## Timing
- Latency is exactly STAGES cycles from accept edge to out_valid, with no stall.
- Throughput is 1 op/cycle when out_ready is held high.
- Capacity is STAGES operations in flight. With out_ready low, in_ready drops once all stages are full, i.e. after STAGES accepts.
- The cycle out_ready rises on a full pipe, in_ready rises in the same cycle, so the pipe stays full without a bubble.
- Reset mid-operation: in-flight ops are lost and out_valid = 0 the cycle after the reset edge. in_ready returns the first cycle rst is low.
- Operation order is strictly preserved.

## Test plan
- Add, WIDTH=32, STAGES=2: a=0xFFFF_FFFF, b=1, cin=0, sub=0 -> 2 cycles later sum=0, cout=1, zero=1, ovf=0.
- Subtract and overflow:
  - a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
  - a=3, b=5, sub=1 -> sum=0xFFFF_FFFE, cout=0.
  - a=0x7FFF_FFFF, b=1, sub=0 -> ovf=1.
- Backpressure: out_ready=0, stream tags 1,2,3 -> in_ready=0 after 2 accepts and out_tag=1 held stable. Raise out_ready -> tags 1,2,3 emerge in order, with no loss or duplicate.
- Flush: two ops in flight plus one offered in the same cycle as flush=1 -> out_valid=0 the next cycle. The offered op is not accepted (in_ready=0). The following op completes normally.
- Reset mid-stream: rst=1 for 1 cycle with ops in flight -> out_valid=0 and sum=0 after the edge; no stale result emerges later.
- Parameter sweep: WIDTH ∈ {8,16,32,64} × every legal STAGES, 10k random a/b/sub/cin with random out_ready. Every output matches a + b_eff + c0 as the golden model, and latency equals STAGES when unstalled.
